cpu_sdram_bridge: RTL

Bus slave between the small CPU master (READn/WRn/WAITn strobe bus) and the SDRAM controller's request port. Posts CPU writes into a small FIFO so the CPU sees one-cycle write completion. Drains the FIFO to memory in order. Performs reads only after all posted writes have drained, so reads always observe earlier writes.

---
 rtl/cpu_sdram_bridge_pkg.sv | 10 +
 rtl/post_wr_fifo.sv | 45 ++++
 rtl/cpu_sdram_bridge.sv | 97 +++++++++
 3 files changed

// File: rtl/cpu_sdram_bridge_pkg.sv
// cpu_sdram_bridge_pkg: shared widths, CPU-side FSM states and posted-write entry type.
package cpu_sdram_bridge_pkg;
  localparam int ADDR_W_DEF = 20;
  localparam int DATA_W_DEF = 16;
  typedef enum logic [2:0] {IDLE, WR_FULL, RD_DRAIN, RD_REQ, RD_DATA, RELEASE} state_t;
  typedef struct packed {
    logic [ADDR_W_DEF-1:0] addr;
    logic [DATA_W_DEF-1:0] data;
  } wr_entry_t;
endpackage

// File: rtl/post_wr_fifo.sv
// post_wr_fifo: posted-write FIFO; o_head_nxt is the entry that will be at the head after this edge.
module post_wr_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 36,
  localparam int PW = $clog2(DEPTH),
  localparam int LW = PW + 1
) (
  input  logic          CLK,
  input  logic          RSTn,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic [W-1:0]  i_din,
  output logic [W-1:0]  o_head_nxt,
  output logic          o_full,
  output logic          o_empty,
  output logic [LW-1:0] o_level,
  output logic [LW-1:0] o_level_nxt
);
  logic [W-1:0] r_mem [DEPTH];
  logic [PW-1:0] r_wr, r_rd;
  logic [LW-1:0] r_level;
  logic w_push, w_pop;
  logic [PW-1:0] w_rd_nxt;
  assign o_level = r_level;
  assign o_full = r_level == LW'(DEPTH);
  assign o_empty = r_level == '0;
  assign w_push = i_push & ~o_full;
  assign w_pop = i_pop & ~o_empty;
  assign w_rd_nxt = r_rd + PW'(w_pop);
  assign o_level_nxt = r_level + LW'(w_push) - LW'(w_pop);
  // When the pop empties the array, only a same-edge push can become the head
  assign o_head_nxt = (r_level == LW'(w_pop)) ? i_din : r_mem[w_rd_nxt];
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      r_wr <= '0;
      r_rd <= '0;
      r_level <= '0;
    end else begin
      if (w_push) r_mem[r_wr] <= i_din;
      r_wr <= r_wr + PW'(w_push);
      r_rd <= w_rd_nxt;
      r_level <= o_level_nxt;
    end
  end
endmodule

// File: rtl/cpu_sdram_bridge.sv
// cpu_sdram_bridge: CPU strobe-bus slave posting writes to a FIFO and issuing ordered reads to SDRAM.
module cpu_sdram_bridge import cpu_sdram_bridge_pkg::*; #(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int FIFO_DEPTH = 4,
  localparam int LW = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic [ADDR_W-1:0] CPU_ADDRESS,
  input  logic [DATA_W-1:0] CPU_WDATA,
  output logic [DATA_W-1:0] CPU_RDATA,
  input  logic              CPU_READn,
  input  logic              CPU_WRn,
  output logic              CPU_WAITn,
  output logic              MEM_REQ,
  output logic              MEM_WE,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic [DATA_W-1:0] MEM_WDATA,
  input  logic              MEM_ACK,
  input  logic              MEM_RVALID,
  input  logic [DATA_W-1:0] MEM_RDATA,
  output logic [LW-1:0]     FIFO_LEVEL
);
  state_t r_st, w_st_nxt;
  logic [DATA_W-1:0] r_rdata, r_mem_wdata;
  logic [ADDR_W-1:0] r_addr, r_mem_addr;
  logic r_waitn, r_mem_req, r_mem_we;
  logic w_push, w_pop, w_rd_done, w_full, w_empty, w_wr_req, w_rd_req;
  logic [LW-1:0] w_lvl_nxt;
  logic [ADDR_W+DATA_W-1:0] w_head_nxt;
  assign CPU_RDATA = r_rdata;
  assign CPU_WAITn = r_waitn;
  assign MEM_REQ = r_mem_req;
  assign MEM_WE = r_mem_we;
  assign MEM_ADDR = r_mem_addr;
  assign MEM_WDATA = r_mem_wdata;
  assign w_pop = r_mem_req & r_mem_we & MEM_ACK;
  assign w_rd_req = w_st_nxt == RD_REQ;
  assign w_wr_req = (w_lvl_nxt != '0) && (w_st_nxt != RD_REQ) && (w_st_nxt != RD_DATA);
  post_wr_fifo #(.DEPTH(FIFO_DEPTH), .W(ADDR_W + DATA_W)) u_fifo (
    .CLK(CLK), .RSTn(RSTn), .i_push(w_push), .i_pop(w_pop),
    .i_din({CPU_ADDRESS, CPU_WDATA}), .o_head_nxt(w_head_nxt),
    .o_full(w_full), .o_empty(w_empty), .o_level(FIFO_LEVEL), .o_level_nxt(w_lvl_nxt)
  );
  always_comb begin
    w_st_nxt = r_st;
    w_push = 1'b0;
    w_rd_done = 1'b0;
    case (r_st)
      IDLE:
        if (!CPU_WRn) begin
          w_push = !w_full;
          w_st_nxt = w_full ? WR_FULL : RELEASE;
        end else if (!CPU_READn) w_st_nxt = RD_DRAIN;
      WR_FULL: begin
        w_push = !w_full;
        w_st_nxt = w_full ? WR_FULL : RELEASE;
      end
      // A read may only go out once every posted write has been accepted
      RD_DRAIN: w_st_nxt = (w_empty && !r_mem_req) ? RD_REQ : RD_DRAIN;
      RD_REQ: w_st_nxt = (MEM_ACK && r_mem_req) ? RD_DATA : RD_REQ;
      RD_DATA: begin
        w_rd_done = MEM_RVALID;
        w_st_nxt = MEM_RVALID ? RELEASE : RD_DATA;
      end
      RELEASE: w_st_nxt = (CPU_READn && CPU_WRn) ? IDLE : RELEASE;
      default: w_st_nxt = IDLE;
    endcase
  end
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      r_st <= IDLE;
      r_waitn <= 1'b0;
      r_rdata <= '0;
      r_addr <= '0;
      r_mem_req <= 1'b0;
      r_mem_we <= 1'b0;
      r_mem_addr <= '0;
      r_mem_wdata <= '0;
    end else begin
      r_st <= w_st_nxt;
      r_waitn <= w_push | w_rd_done;
      if (w_rd_done) r_rdata <= MEM_RDATA;
      if (r_st == IDLE && w_st_nxt == RD_DRAIN) r_addr <= CPU_ADDRESS;
      r_mem_req <= w_wr_req | w_rd_req;
      if (w_wr_req) begin
        r_mem_we <= 1'b1;
        r_mem_addr <= w_head_nxt[ADDR_W+DATA_W-1:DATA_W];
        r_mem_wdata <= w_head_nxt[DATA_W-1:0];
      end else if (w_rd_req) begin
        r_mem_we <= 1'b0;
        r_mem_addr <= r_addr;
      end
    end
  end
endmodule
